// File: rtl/seq_mul_add_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_mul_add_pkg                                               |
// | Brief    : Shared types and helpers for the seq_mul_add engine.          |
// |            Option macro: SEQ_MUL_ADD_SAT_EN (saturate on overflow).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package seq_mul_add_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    SF = 2'd3
  } state_e;

  // Widest full-precision result the helpers handle, i.e. DW up to 63.
  localparam int MAX_W = 128;

`ifdef SEQ_MUL_ADD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  function automatic int fw(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic logic [MAX_W-1:0] sat_trunc(input logic [MAX_W-1:0] full,
                                                 input logic             ovf,
                                                 input int               ow);
    logic [MAX_W-1:0] mask;
    mask = (ow >= MAX_W) ? '1 : ((MAX_W'(1) << ow) - MAX_W'(1));
    if (SAT_EN && ovf) return mask;
    return full & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul_add_dp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_mul_add_dp                                                |
// | Brief    : Combinational a*b+c at full width, overflow detect and        |
// |            wrap/saturate to OW bits (SEQ_MUL_ADD_SAT_EN selects sat).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_mul_add_dp
  import seq_mul_add_pkg::*;
#(
  parameter int DW = 32,
  parameter int OW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic [OW-1:0] data_out,
  output logic          ovf
);

  localparam int FW = fw(DW);

  logic [FW-1:0] full;

  assign full = FW'(a) * FW'(b) + FW'(c);

  generate
    if (OW < FW) begin : g_ovf
      assign ovf = |full[FW-1:OW];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

  assign data_out = OW'(sat_trunc(MAX_W'(full), ovf, OW));

endmodule
`default_nettype wire

// File: rtl/seq_mul_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_mul_add                                                   |
// | Brief    : Streaming multiply-add: data_out = a*b + c over three         |
// |            consecutive samples, block or sliding-window grouping.        |
// |            Option macro: SEQ_MUL_ADD_SAT_EN (saturate on overflow).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_mul_add
  import seq_mul_add_pkg::*;
#(
  parameter int DW = 32,
  parameter int OW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          validi,
  input  logic [DW-1:0] data_in,
  input  logic          slide,
  output logic          valido,
  output logic [OW-1:0] data_out,
  output logic          ovf
);

  state_e        state_q, state_d;
  logic [DW-1:0] s1_q, s1_d;
  logic [DW-1:0] s2_q, s2_d;
  logic          valido_q, valido_d;
  logic [OW-1:0] data_out_q, data_out_d;
  logic          ovf_q, ovf_d;
  logic          strobe;
  logic [OW-1:0] dp_data;
  logic          dp_ovf;

  // s2 holds the oldest sample, s1 the middle one; the newest is data_in itself.
  seq_mul_add_dp #(
    .DW(DW),
    .OW(OW)
  ) u_dp (
    .a       (s2_q),
    .b       (s1_q),
    .c       (data_in),
    .data_out(dp_data),
    .ovf     (dp_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S0;
      s1_q       <= '0;
      s2_q       <= '0;
      valido_q   <= 1'b0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      valido_q   <= valido_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin : next_state
    state_d = S0;
    if (validi) begin
      case (state_q)
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = slide ? SF : S0;
        SF:      state_d = slide ? SF : S1;
        default: state_d = S0;
      endcase
    end
  end

  always_comb begin : outputs
    strobe     = validi && ((state_q == S2) || ((state_q == SF) && slide));
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (validi) begin
      s2_d = s1_q;
      s1_d = data_in;
    end
    valido_d   = strobe;
    data_out_d = strobe ? dp_data : data_out_q;
    ovf_d      = strobe ? dp_ovf  : ovf_q;
  end

  assign valido   = valido_q;
  assign data_out = data_out_q;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_mul_add                                                |
// | Brief    : Self-checking bench for seq_mul_add (32/32 and 8/8 builds).   |
// |            Honours SEQ_MUL_ADD_SAT_EN for saturation expectations.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_mul_add;

`ifdef SEQ_MUL_ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        validi = 1'b0;
  logic [31:0] data_in = '0;
  logic        slide = 1'b0;
  logic        valido;
  logic [31:0] data_out;
  logic        ovf;

  logic        n_validi = 1'b0;
  logic [7:0]  n_data_in = '0;
  logic        n_valido;
  logic [7:0]  n_data_out;
  logic        n_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mul_add #(.DW(32), .OW(32)) u_wide (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in), .slide(slide),
    .valido(valido), .data_out(data_out), .ovf(ovf)
  );

  seq_mul_add #(.DW(8), .OW(8)) u_narrow (
    .clk(clk), .rst(rst), .validi(n_validi), .data_in(n_data_in), .slide(1'b0),
    .valido(n_valido), .data_out(n_data_out), .ovf(n_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a window of consecutive samples; three in the window make a result.
  logic [31:0] win[$];
  bit          m_after_slide;
  bit          m_valido;
  logic [31:0] m_data;
  bit          m_ovf;

  task automatic model_reset();
    win.delete();
    m_after_slide = 1'b0;
    m_valido      = 1'b0;
    m_data        = '0;
    m_ovf         = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit s);
    logic [127:0] full;
    m_valido = 1'b0;
    if (!v) begin
      win.delete();
      m_after_slide = 1'b0;
      return;
    end
    if (m_after_slide && !s) win.delete();
    m_after_slide = 1'b0;
    win.push_back(d);
    if (win.size() == 3) begin
      full     = 128'(win[0]) * 128'(win[1]) + 128'(win[2]);
      m_ovf    = |full[127:32];
      m_data   = (SAT && m_ovf) ? 32'hFFFF_FFFF : full[31:0];
      m_valido = 1'b1;
      if (s) begin
        void'(win.pop_front());
        m_after_slide = 1'b1;
      end else begin
        win.delete();
      end
    end
  endtask

  task automatic wstep(input bit v, input logic [31:0] d, input bit s);
    validi  = v;
    data_in = d;
    slide   = s;
    @(posedge clk);
    model_edge(v, d, s);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valido"},   valido,   m_valido);
    check({tag, ".data_out"}, data_out, m_data);
    check({tag, ".ovf"},      ovf,      m_ovf);
  endtask

  task automatic nstep(input bit v, input logic [7:0] d);
    n_validi  = v;
    n_data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic ntriple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [16:0] full;
    logic        e_ovf;
    logic [7:0]  e_data;
    full   = 17'(a) * 17'(b) + 17'(c);
    e_ovf  = full > 17'd255;
    e_data = (SAT && e_ovf) ? 8'hFF : full[7:0];
    nstep(1'b1, a);
    check("narrow.no_strobe_1", n_valido, 1'b0);
    nstep(1'b1, b);
    check("narrow.no_strobe_2", n_valido, 1'b0);
    nstep(1'b1, c);
    check("narrow.valido", n_valido, 1'b1);
    check("narrow.data_out", n_data_out, e_data);
    check("narrow.ovf", n_ovf, e_ovf);
    nstep(1'b0, 8'd0);
    check("narrow.gap_valido", n_valido, 1'b0);
    check("narrow.hold_data", n_data_out, e_data);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          s;
    bit          ev;
    logic [31:0] ed;
    bit          eo;
  } vec_t;

  function automatic vec_t mk(input bit v, input logic [31:0] d, input bit s,
                              input bit ev, input logic [31:0] ed);
    vec_t r;
    r.v = v; r.d = d; r.s = s; r.ev = ev; r.ed = ed; r.eo = 1'b0;
    return r;
  endfunction

  initial begin
    vec_t        tbl[$];
    logic [31:0] held;
    bit          rs;

    // Block mode 2..7
    tbl.push_back(mk(1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4, 0, 1, 10));
    tbl.push_back(mk(1, 5, 0, 0, 10));
    tbl.push_back(mk(1, 6, 0, 0, 10));
    tbl.push_back(mk(1, 7, 0, 1, 37));
    tbl.push_back(mk(0, 0, 0, 0, 37));
    // Broken runs 1-0, 1-1-0, 1-1-0-1-1-1
    tbl.push_back(mk(1, 9, 0, 0, 37));
    tbl.push_back(mk(0, 0, 0, 0, 37));
    tbl.push_back(mk(1, 9, 0, 0, 37));
    tbl.push_back(mk(1, 9, 0, 0, 37));
    tbl.push_back(mk(0, 0, 0, 0, 37));
    tbl.push_back(mk(1, 9, 0, 0, 37));
    tbl.push_back(mk(1, 9, 0, 0, 37));
    tbl.push_back(mk(0, 0, 0, 0, 37));
    tbl.push_back(mk(1, 1, 0, 0, 37));
    tbl.push_back(mk(1, 2, 0, 0, 37));
    tbl.push_back(mk(1, 3, 0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 5));
    // Slide mode 1..5, then back to block with 1,1,1
    tbl.push_back(mk(1, 1, 1, 0, 5));
    tbl.push_back(mk(1, 2, 1, 0, 5));
    tbl.push_back(mk(1, 3, 1, 1, 5));
    tbl.push_back(mk(1, 4, 1, 1, 10));
    tbl.push_back(mk(1, 5, 1, 1, 17));
    tbl.push_back(mk(1, 1, 0, 0, 17));
    tbl.push_back(mk(1, 1, 0, 0, 17));
    tbl.push_back(mk(1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 2));

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.valido", valido, 1'b0);
    check("reset.data_out", data_out, 32'd0);
    check("reset.ovf", ovf, 1'b0);
    #3 rst = 1'b1;

    foreach (tbl[i]) begin
      wstep(tbl[i].v, tbl[i].d, tbl[i].s);
      check($sformatf("vec%0d.valido", i), valido, tbl[i].ev);
      check($sformatf("vec%0d.data_out", i), data_out, tbl[i].ed);
      check($sformatf("vec%0d.ovf", i), ovf, tbl[i].eo);
    end

    // Overflowing strobe followed by ten idle cycles of hold
    held = SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
    wstep(1, 32'hFFFF_FFFF, 0);
    wstep(1, 32'd2, 0);
    wstep(1, 32'd0, 0);
    check("wide_ovf.valido", valido, 1'b1);
    check("wide_ovf.data_out", data_out, held);
    check("wide_ovf.ovf", ovf, 1'b1);
    for (int i = 0; i < 10; i++) begin
      wstep(0, 32'd0, 0);
      check("hold.valido", valido, 1'b0);
      check("hold.data_out", data_out, held);
      check("hold.ovf", ovf, 1'b1);
    end

    // Reset mid-group: two samples, then asynchronous reset between edges
    wstep(1, 32'd7, 0);
    wstep(1, 32'd8, 0);
    validi  = 1'b1;
    data_in = 32'd11;
    #3 rst = 1'b0;
    #1;
    check("midreset.valido", valido, 1'b0);
    check("midreset.data_out", data_out, 32'd0);
    check("midreset.ovf", ovf, 1'b0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("inreset.valido", valido, 1'b0);
      check("inreset.data_out", data_out, 32'd0);
    end
    #3 rst = 1'b1;
    wstep(1, 32'd2, 0);
    check("postreset.s1", valido, 1'b0);
    wstep(1, 32'd3, 0);
    check("postreset.s2", valido, 1'b0);
    wstep(1, 32'd4, 0);
    check("postreset.valido", valido, 1'b1);
    check("postreset.data_out", data_out, 32'd10);
    check_model("postreset");
    wstep(0, 32'd0, 0);
    check_model("postreset_gap");

    // Randomised run against the reference model
    rs = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 20) rs = ~rs;
      wstep($urandom_range(0, 99) < 80,
            ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255)),
            rs);
      check_model("rand");
    end
    wstep(0, 32'd0, 0);

    // Narrow 8/8 build: overflow and non-overflow cases, then random triples
    ntriple(8'd16, 8'd16, 8'd1);
    ntriple(8'd3, 8'd4, 8'd5);
    ntriple(8'd0, 8'd0, 8'd255);
    ntriple(8'd255, 8'd255, 8'd255);
    for (int i = 0; i < 30; i++) begin
      ntriple(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
